// File: rtl/led_sequencer_if.sv
// Key-side and LED-side signals of the LED sequencer, bundled for the top-level port list.
// The master drives the controls; the slave (the sequencer) drives the LED outputs.
interface led_sequencer_if #(
  parameter int NUM_LEDS = 8
);
  logic [1:0]          in_mode;
  logic                in_dir;
  logic                in_pause;
  logic                in_step;
  logic [NUM_LEDS-1:0] out_leds;
  logic [NUM_LEDS-1:0] out_leds_n;
  logic                out_step;

  modport master (
    output in_mode, in_dir, in_pause, in_step,
    input  out_leds, out_leds_n, out_step
  );

  modport slave (
    input  in_mode, in_dir, in_pause, in_step,
    output out_leds, out_leds_n, out_step
  );
endinterface

// File: rtl/led_sequencer.sv
// LED pattern generator: bounce / rotate / bar / blink at a divided step rate,
// with pause and manual single-step. All state is synchronous to in_clk.
module led_sequencer #(
  parameter int NUM_LEDS    = 8,
  parameter int MAIN_CLK_HZ = 27_000_000,
  parameter int STEP_HZ     = 4
) (
  input  logic           in_clk,
  input  logic           in_rst,
  led_sequencer_if.slave bus
);
  localparam int DIV   = MAIN_CLK_HZ / STEP_HZ;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int LVL_W = $clog2(NUM_LEDS + 1);

  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [LVL_W-1:0]    LVL_MAX  = LVL_W'(NUM_LEDS);
  localparam logic [LVL_W-1:0]    LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [NUM_LEDS-1:0] PAT_ONE  = {{(NUM_LEDS-1){1'b0}}, 1'b1};
  localparam logic [NUM_LEDS-1:0] PAT_ZERO = {NUM_LEDS{1'b0}};
  localparam logic [NUM_LEDS-1:0] PAT_ALL  = {NUM_LEDS{1'b1}};

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BAR    = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic                step_q, step_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [NUM_LEDS-1:0] leds_n_q, leds_n_d;
  logic                dir_q, dir_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic                out_step_q, out_step_d;

  logic                tick;
  logic                step_ev;
  logic                mode_chg;
  logic [NUM_LEDS-1:0] next_pat;
  logic                next_dir;
  logic [LVL_W-1:0]    next_lvl;

  function automatic logic [NUM_LEDS-1:0] entry_pat(input logic [1:0] m);
    case (m)
      MODE_BOUNCE: entry_pat = PAT_ONE;
      MODE_ROTATE: entry_pat = PAT_ONE;
      MODE_BAR:    entry_pat = PAT_ZERO;
      MODE_BLINK:  entry_pat = PAT_ALL;
      default:     entry_pat = PAT_ONE;
    endcase
  endfunction

  assign tick     = (cnt_q == CNT_MAX) & ~bus.in_pause;
  assign step_ev  = tick | (bus.in_pause & bus.in_step & ~step_q);
  assign mode_chg = (bus.in_mode != mode_q);

  // dir_q doubles as bounce direction and bar direction: 1 = up / rising
  always_comb begin
    next_pat = leds_q;
    next_dir = dir_q;
    next_lvl = lvl_q;
    case (mode_q)
      MODE_BOUNCE: begin
        if (dir_q) begin
          next_pat = {leds_q[NUM_LEDS-2:0], 1'b0};
          next_dir = ~next_pat[NUM_LEDS-1];
        end else begin
          next_pat = {1'b0, leds_q[NUM_LEDS-1:1]};
          next_dir = next_pat[0];
        end
      end
      MODE_ROTATE: begin
        if (bus.in_dir) begin
          next_pat = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
        end else begin
          next_pat = {leds_q[0], leds_q[NUM_LEDS-1:1]};
        end
      end
      MODE_BAR: begin
        if (dir_q) begin
          next_lvl = lvl_q + LVL_W'(1);
          next_dir = (next_lvl != LVL_MAX);
        end else begin
          next_lvl = lvl_q - LVL_W'(1);
          next_dir = (next_lvl == LVL_ZERO);
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
          next_pat[i] = (LVL_W'(i) < next_lvl);
        end
      end
      MODE_BLINK: begin
        next_pat = ~leds_q;
      end
      default: begin
        next_pat = leds_q;
      end
    endcase
  end

  // A mode change reloads the entry pattern and drops any coincident step
  always_comb begin
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    step_d     = bus.in_step;
    leds_d     = leds_q;
    dir_d      = dir_q;
    lvl_d      = lvl_q;
    out_step_d = 1'b0;
    if (mode_chg) begin
      mode_d = bus.in_mode;
      cnt_d  = CNT_ZERO;
      leds_d = entry_pat(bus.in_mode);
      dir_d  = 1'b1;
      lvl_d  = LVL_ZERO;
    end else begin
      if (bus.in_pause) begin
        cnt_d = cnt_q;
      end else if (tick) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (step_ev) begin
        leds_d     = next_pat;
        dir_d      = next_dir;
        lvl_d      = next_lvl;
        out_step_d = 1'b1;
      end else begin
        out_step_d = 1'b0;
      end
    end
    leds_n_d = ~leds_d;
  end

  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      cnt_q      <= CNT_ZERO;
      mode_q     <= bus.in_mode;
      step_q     <= bus.in_step;
      leds_q     <= PAT_ONE;
      leds_n_q   <= ~PAT_ONE;
      dir_q      <= 1'b1;
      lvl_q      <= LVL_ZERO;
      out_step_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      leds_q     <= leds_d;
      leds_n_q   <= leds_n_d;
      dir_q      <= dir_d;
      lvl_q      <= lvl_d;
      out_step_q <= out_step_d;
    end
  end

  assign bus.out_leds   = leds_q;
  assign bus.out_leds_n = leds_n_q;
  assign bus.out_step   = out_step_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with NUM_LEDS=4, DIV=4; inputs driven and
// outputs sampled on the falling edge.
module tb_led_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] cur;

  always #5 clk = ~clk;

  led_sequencer_if #(.NUM_LEDS(4)) bus ();

  led_sequencer #(
    .NUM_LEDS   (4),
    .MAIN_CLK_HZ(8),
    .STEP_HZ    (2)
  ) dut (
    .in_clk(clk),
    .in_rst(rst),
    .bus   (bus)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] exp_leds, input logic exp_step);
    logic [3:0] inv;
    inv = ~exp_leds;
    chk({tag, "_leds"}, {28'd0, bus.out_leds}, {28'd0, exp_leds});
    chk({tag, "_leds_n"}, {28'd0, bus.out_leds_n}, {28'd0, inv});
    chk({tag, "_step"}, {31'd0, bus.out_step}, {31'd0, exp_step});
  endtask

  // Three quiet cycles, then the stepped value with a one-cycle out_step pulse
  task automatic step_chk(input string tag, input logic [3:0] exp);
    cyc(3);
    chk_state({tag, "_hold"}, cur, 1'b0);
    cyc(1);
    chk_state(tag, exp, 1'b1);
    cur = exp;
  endtask

  initial begin
    rst          = 1'b0;
    bus.in_mode  = 2'd0;
    bus.in_dir   = 1'b1;
    bus.in_pause = 1'b0;
    bus.in_step  = 1'b0;
    cyc(2);
    chk_state("reset", 4'b0001, 1'b0);

    // 1: bounce
    rst = 1'b1;
    cur = 4'b0001;
    step_chk("b1", 4'b0010);
    step_chk("b2", 4'b0100);
    step_chk("b3", 4'b1000);
    step_chk("b4", 4'b0100);
    step_chk("b5", 4'b0010);
    step_chk("b6", 4'b0001);

    // 2: rotate
    bus.in_mode = 2'd1;
    cyc(1);
    chk_state("rot_entry", 4'b0001, 1'b0);
    cur = 4'b0001;
    step_chk("r1", 4'b0010);
    step_chk("r2", 4'b0100);
    step_chk("r3", 4'b1000);
    step_chk("r4_wrap", 4'b0001);
    step_chk("r5", 4'b0010);
    step_chk("r6", 4'b0100);
    bus.in_dir = 1'b0;
    step_chk("r7_down", 4'b0010);
    step_chk("r8_down", 4'b0001);
    step_chk("r9_wrap", 4'b1000);

    // 3: bar
    bus.in_mode = 2'd2;
    cyc(1);
    chk_state("bar_entry", 4'b0000, 1'b0);
    cur = 4'b0000;
    step_chk("bar1", 4'b0001);
    step_chk("bar2", 4'b0011);
    step_chk("bar3", 4'b0111);
    step_chk("bar4", 4'b1111);
    step_chk("bar5", 4'b0111);
    step_chk("bar6", 4'b0011);
    step_chk("bar7", 4'b0001);
    step_chk("bar8", 4'b0000);
    step_chk("bar9", 4'b0001);

    // 4: blink with pause and manual steps
    bus.in_mode = 2'd3;
    cyc(1);
    chk_state("blink_entry", 4'b1111, 1'b0);
    cyc(1);
    bus.in_pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk_state("paused", 4'b1111, 1'b0);
    end
    bus.in_step = 1'b1;
    cyc(1);
    chk_state("man1", 4'b0000, 1'b1);
    bus.in_step = 1'b0;
    cyc(1);
    chk_state("man1_after", 4'b0000, 1'b0);
    bus.in_step = 1'b1;
    cyc(1);
    chk_state("man2", 4'b1111, 1'b1);
    bus.in_step = 1'b0;
    cyc(1);
    chk_state("man2_after", 4'b1111, 1'b0);
    bus.in_step = 1'b1;
    cyc(1);
    chk_state("man3", 4'b0000, 1'b1);
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      chk_state("step_held", 4'b0000, 1'b0);
    end
    bus.in_step = 1'b0;
    cyc(1);
    bus.in_pause = 1'b0;
    cyc(2);
    chk_state("resume_hold", 4'b0000, 1'b0);
    cyc(1);
    chk_state("resume_tick", 4'b1111, 1'b1);

    // 5: mode change coincident with a tick
    bus.in_mode = 2'd0;
    cyc(1);
    chk_state("to_bounce", 4'b0001, 1'b0);
    cyc(3);
    chk_state("pre_tick", 4'b0001, 1'b0);
    bus.in_mode = 2'd2;
    cyc(1);
    chk_state("chg_wins", 4'b0000, 1'b0);
    cyc(2);
    chk_state("chg_wait", 4'b0000, 1'b0);
    cyc(1);
    chk_state("chg_wait3", 4'b0000, 1'b0);
    cyc(1);
    chk_state("chg_full_div", 4'b0001, 1'b1);

    // 6: reset mid-bounce while moving down
    bus.in_mode = 2'd0;
    cyc(1);
    chk_state("b_entry", 4'b0001, 1'b0);
    cur = 4'b0001;
    step_chk("m1", 4'b0010);
    step_chk("m2", 4'b0100);
    step_chk("m3", 4'b1000);
    step_chk("m4_down", 4'b0100);
    rst = 1'b0;
    cyc(1);
    chk_state("mid_reset", 4'b0001, 1'b0);
    rst = 1'b1;
    cur = 4'b0001;
    step_chk("post_rst1", 4'b0010);
    step_chk("post_rst2", 4'b0100);
    step_chk("post_rst3", 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
